uart_apb_ctrl: RTL

- APB completer that owns the simulation UART in SimTop. It converts core APB accesses into a buffered TX character stream for the testbench console and a buffered RX stream from the host.
- Provides status and control registers and the level interrupt `uart_irq`.
- Sits between the SoC peripheral APB port and the testbench `io_uart_out_*` / host-input hooks.

---
 rtl/uart_apb_pkg.sv | 27 ++
 rtl/uart_apb_ctrl_if.sv | 27 ++
 rtl/uart_sync_fifo.sv | 54 +++++
 rtl/uart_apb_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// Shared definitions for the simulation UART: register word offsets, STATUS/CTRL
// bit positions and the TX drain state encoding.
package uart_apb_pkg;

   // Word index taken from paddr[3:2]
   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_RXDATA = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam int ST_TXFULL  = 0;
   localparam int ST_TXEMPTY = 1;
   localparam int ST_RXFULL  = 2;
   localparam int ST_RXEMPTY = 3;
   localparam int ST_TXOVF   = 4;
   localparam int ST_RXOVF   = 5;

   localparam int CTRL_TXIE = 0;
   localparam int CTRL_RXIE = 1;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_EMIT = 2'd1,
      TX_GAP  = 2'd2
   } tx_state_e;

endpackage

// File: rtl/uart_apb_ctrl_if.sv
// APB completer bus plus the console TX and host RX hooks of the simulation UART.
interface uart_apb_ctrl_if;
   logic [63:0] uart_paddr;
   logic        uart_psel;
   logic        uart_penable;
   logic        uart_pwrite;
   logic [31:0] uart_pwdata;
   logic [3:0]  uart_pstrb;
   logic [31:0] uart_prdata;
   logic        uart_irq;
   logic        io_uart_out_valid;
   logic [7:0]  io_uart_out_ch;
   logic        io_uart_in_valid;
   logic [7:0]  io_uart_in_ch;

   modport slave (
      input  uart_paddr, uart_psel, uart_penable, uart_pwrite, uart_pwdata, uart_pstrb,
      output uart_prdata, uart_irq, io_uart_out_valid, io_uart_out_ch,
      input  io_uart_in_valid, io_uart_in_ch
   );

   modport master (
      output uart_paddr, uart_psel, uart_penable, uart_pwrite, uart_pwdata, uart_pstrb,
      input  uart_prdata, uart_irq, io_uart_out_valid, io_uart_out_ch,
      output io_uart_in_valid, io_uart_in_ch
   );
endinterface

// File: rtl/uart_sync_fifo.sv
// Small first-word-fall-through FIFO; a push into a full FIFO is accepted when a
// pop happens in the same cycle.
module uart_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem[rd_ptr_q];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr_q] <= din;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/uart_apb_ctrl.sv
// APB-attached simulation UART: buffered TX stream to the console, buffered RX
// stream from the host, STATUS/CTRL registers and a registered level interrupt.
module uart_apb_ctrl
   import uart_apb_pkg::*;
#(
   parameter int TX_DEPTH   = 16,
   parameter int RX_DEPTH   = 8,
   parameter int CHAR_GAP   = 0,
   parameter int ADDR_LSB_W = 4
) (
   input  logic            clock,
   input  logic            reset,
   uart_apb_ctrl_if.slave  bus
);
   localparam int TX_CW = $clog2(TX_DEPTH) + 1;
   localparam int RX_CW = $clog2(RX_DEPTH) + 1;
   localparam int GAP_W = (CHAR_GAP > 1) ? $clog2(CHAR_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((CHAR_GAP > 0) ? CHAR_GAP - 1 : 0);

   logic [ADDR_LSB_W-1:0] addr_lo;
   logic [1:0]            reg_sel;
   logic                  access, wr_en, rd_en, status_wr, ctrl_wr;
   logic                  tx_push_req, tx_push, tx_pop, tx_full, tx_empty;
   logic                  rx_push, rx_pop, rx_full, rx_empty;
   logic [TX_CW-1:0]      tx_count;
   logic [RX_CW-1:0]      rx_count;
   logic [7:0]            tx_head, rx_head;
   logic [31:0]           prdata;

   tx_state_e        state_q, state_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [1:0]       ctrl_q, ctrl_d;
   logic             txovf_q, txovf_d, rxovf_q, rxovf_d, irq_q, irq_d;
   logic [7:0]       out_ch_q, out_ch_d;
   logic             unused_bits;

   assign addr_lo   = bus.uart_paddr[ADDR_LSB_W-1:0];
   assign reg_sel   = addr_lo[3:2];
   assign access    = bus.uart_psel & bus.uart_penable;
   assign wr_en     = access & bus.uart_pwrite;
   assign rd_en     = access & ~bus.uart_pwrite;
   assign status_wr = wr_en & (reg_sel == REG_STATUS) & bus.uart_pstrb[0];
   assign ctrl_wr   = wr_en & (reg_sel == REG_CTRL) & bus.uart_pstrb[0];

   assign tx_pop      = (state_q == TX_EMIT);
   assign tx_push_req = wr_en & (reg_sel == REG_TXDATA) & bus.uart_pstrb[0];
   assign tx_push     = tx_push_req & (~tx_full | tx_pop);
   assign rx_pop      = rd_en & (reg_sel == REG_RXDATA) & ~rx_empty;
   assign rx_push     = bus.io_uart_in_valid & (~rx_full | rx_pop);

   assign unused_bits = ^{bus.uart_paddr, addr_lo[1:0], bus.uart_pwdata[31:8], bus.uart_pstrb[3:1]};

   uart_sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
      .clock(clock), .reset(reset), .push(tx_push), .pop(tx_pop),
      .din(bus.uart_pwdata[7:0]), .dout(tx_head),
      .full(tx_full), .empty(tx_empty), .count(tx_count)
   );

   uart_sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
      .clock(clock), .reset(reset), .push(rx_push), .pop(rx_pop),
      .din(bus.io_uart_in_ch), .dout(rx_head),
      .full(rx_full), .empty(rx_empty), .count(rx_count)
   );

   // When the gap expires the drain goes straight to EMIT if data is waiting,
   // so characters are spaced exactly CHAR_GAP+1 cycles apart.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      case (state_q)
         TX_IDLE: if (!tx_empty) state_d = TX_EMIT;
         TX_EMIT: begin
            if (CHAR_GAP > 0) begin
               state_d = TX_GAP;
               gap_d   = GAP_LOAD;
            end else if ((tx_count > TX_CW'(1)) || tx_push) begin
               state_d = TX_EMIT;
            end else begin
               state_d = TX_IDLE;
            end
         end
         TX_GAP: begin
            if (gap_q == '0) state_d = tx_empty ? TX_IDLE : TX_EMIT;
            else             gap_d   = gap_q - GAP_W'(1);
         end
         default: state_d = TX_IDLE;
      endcase
   end

   // Sticky overflow flags: a new overflow wins over a same-cycle W1C.
   always_comb begin
      ctrl_d   = ctrl_wr ? bus.uart_pwdata[1:0] : ctrl_q;
      txovf_d  = (txovf_q & ~(status_wr & bus.uart_pwdata[ST_TXOVF])) | (tx_push_req & ~tx_push);
      rxovf_d  = (rxovf_q & ~(status_wr & bus.uart_pwdata[ST_RXOVF])) | (bus.io_uart_in_valid & ~rx_push);
      irq_d    = (ctrl_q[CTRL_TXIE] & tx_empty) | (ctrl_q[CTRL_RXIE] & ~rx_empty) | txovf_q | rxovf_q;
      out_ch_d = tx_pop ? tx_head : out_ch_q;
   end

   always_comb begin
      prdata = '0;
      if (access && reset) begin
         case (reg_sel)
            REG_RXDATA: prdata = {rx_empty, 23'b0, rx_empty ? 8'h00 : rx_head};
            REG_STATUS: begin
               prdata[ST_TXFULL]  = tx_full;
               prdata[ST_TXEMPTY] = tx_empty;
               prdata[ST_RXFULL]  = rx_full;
               prdata[ST_RXEMPTY] = rx_empty;
               prdata[ST_TXOVF]   = txovf_q;
               prdata[ST_RXOVF]   = rxovf_q;
               prdata[15:8]       = 8'(tx_count);
               prdata[23:16]      = 8'(rx_count);
            end
            REG_CTRL:   prdata = {30'b0, ctrl_q};
            default:    prdata = '0;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= TX_IDLE;
         gap_q    <= '0;
         ctrl_q   <= '0;
         txovf_q  <= 1'b0;
         rxovf_q  <= 1'b0;
         irq_q    <= 1'b0;
         out_ch_q <= '0;
      end else begin
         state_q  <= state_d;
         gap_q    <= gap_d;
         ctrl_q   <= ctrl_d;
         txovf_q  <= txovf_d;
         rxovf_q  <= rxovf_d;
         irq_q    <= irq_d;
         out_ch_q <= out_ch_d;
      end
   end

   assign bus.uart_prdata       = prdata;
   assign bus.uart_irq          = irq_q;
   assign bus.io_uart_out_valid = tx_pop;
   assign bus.io_uart_out_ch    = tx_pop ? tx_head : out_ch_q;
endmodule
